clkdiv_multi: RTL and testbench

Multi-channel programmable clock divider, the parametrised successor to the single fixed-ratio divider in the measurement counter design. It generates NCHAN independent square-wave outputs from one source clock. Each channel has a runtime-loadable divisor, a per-channel enable and a one-cycle rising-edge tick. A global sync input re-aligns the phase of every channel. It feeds the counter/measurement logic, which needs several time bases whose rates change without re-synthesis.

---
 rtl/clkdiv_multi_pkg.sv | 43 ++++
 rtl/clkdiv_multi_chan.sv | 117 +++++++++++
 rtl/clkdiv_multi.sv | 45 ++++
 tb/tb_clkdiv_multi.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Holds the default width/divisor and the legacy COUNTVAL-compatible
// values so older single-divider instantiations can migrate unchanged.
package clkdiv_multi_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_DIVISOR = 100000;

  // Legacy single-divider names: one channel at the old fixed ratio.
  localparam int LEGACY_COUNTVAL = 100000;
  localparam int LEGACY_NCHAN    = 1;

  // What a channel does on the coming edge (reset is handled in the register).
  typedef enum logic [1:0] {
    CH_SYNC  = 2'd0,
    CH_IDLE  = 2'd1,
    CH_TERM  = 2'd2,
    CH_COUNT = 2'd3
  } chan_op_e;

  // Priority decode: sync > disabled > terminal count > increment.
  function automatic chan_op_e chan_op(input logic sync,
                                       input logic enable,
                                       input logic at_term);
    chan_op_e op;
    if (sync) begin
      op = CH_SYNC;
    end else if (!enable) begin
      op = CH_IDLE;
    end else if (at_term) begin
      op = CH_TERM;
    end else begin
      op = CH_COUNT;
    end
    return op;
  endfunction

  // Width of a channel selector; never narrower than one bit.
  function automatic int chan_sel_width(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_multi_chan.sv
// One divider channel: counter, active/pending divisor and the
// registered newclk/tick/cfg_pending outputs. A divisor change is only
// applied on a half-period boundary (or restart), so no runt pulses.
module clkdiv_chan
  import clkdiv_multi_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIVISOR)
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             sync,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             newclk,
  output logic             tick,
  output logic             cfg_pending
);

  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] div_active_r, div_active_s;
  logic [WIDTH-1:0] div_pending_r, div_pending_s;
  logic             newclk_r, newclk_s;
  logic             tick_r, tick_s;
  logic             pending_r, pending_s;
  logic             at_term_s;
  chan_op_e         op_s;

  assign at_term_s = (count_r == div_active_r);
  assign op_s      = chan_op(sync, enable, at_term_s);

  // Next-state decode for counter, divisors and output registers.
  always_comb begin
    count_s       = count_r;
    div_active_s  = div_active_r;
    div_pending_s = div_pending_r;
    newclk_s      = newclk_r;
    tick_s        = 1'b0;
    pending_s     = pending_r;
    case (op_s)
      CH_SYNC: begin
        count_s   = {WIDTH{1'b0}};
        newclk_s  = 1'b0;
        pending_s = 1'b0;
        if (cfg_we) begin
          div_active_s  = cfg_div;
          div_pending_s = cfg_div;
        end else begin
          div_active_s  = div_pending_r;
        end
      end
      CH_IDLE: begin
        count_s      = {WIDTH{1'b0}};
        newclk_s     = 1'b0;
        div_active_s = div_pending_r;
        if (cfg_we) begin
          div_pending_s = cfg_div;
          pending_s     = 1'b1;
        end else begin
          pending_s     = 1'b0;
        end
      end
      CH_TERM: begin
        count_s   = {WIDTH{1'b0}};
        newclk_s  = ~newclk_r;
        tick_s    = ~newclk_r;
        pending_s = 1'b0;
        if (cfg_we) begin
          div_active_s  = cfg_div;
          div_pending_s = cfg_div;
        end else begin
          div_active_s  = div_pending_r;
        end
      end
      CH_COUNT: begin
        count_s = count_r + WIDTH'(1'b1);
        if (cfg_we) begin
          div_pending_s = cfg_div;
          pending_s     = 1'b1;
        end else begin
          div_pending_s = div_pending_r;
          pending_s     = pending_r;
        end
      end
      default: begin
        count_s   = {WIDTH{1'b0}};
        newclk_s  = 1'b0;
        pending_s = 1'b0;
      end
    endcase
  end

  // Channel state register with synchronous reset to the default divisor.
  always_ff @(posedge inclk) begin
    if (reset) begin
      count_r       <= {WIDTH{1'b0}};
      div_active_r  <= DEFAULT_DIV;
      div_pending_r <= DEFAULT_DIV;
      newclk_r      <= 1'b0;
      tick_r        <= 1'b0;
      pending_r     <= 1'b0;
    end else begin
      count_r       <= count_s;
      div_active_r  <= div_active_s;
      div_pending_r <= div_pending_s;
      newclk_r      <= newclk_s;
      tick_r        <= tick_s;
      pending_r     <= pending_s;
    end
  end

  assign newclk      = newclk_r;
  assign tick        = tick_r;
  assign cfg_pending = pending_r;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider. NCHAN independent channels
// share the clock, reset, sync and the divisor write port; cfg_chan is
// decoded into per-channel write strobes (out-of-range writes hit nothing).
module clkdiv_multi
  import clkdiv_multi_pkg::*;
#(
  parameter int               NCHAN       = 4,
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIVISOR),
  parameter int               CW          = chan_sel_width(NCHAN)
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic [NCHAN-1:0] enable,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_chan,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [NCHAN-1:0] newclk,
  output logic [NCHAN-1:0] tick,
  output logic [NCHAN-1:0] cfg_pending
);

  logic [NCHAN-1:0] chan_we_s;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    assign chan_we_s[i] = cfg_we & (cfg_chan == CW'(i));

    clkdiv_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .inclk       (inclk),
      .reset       (reset),
      .sync        (sync),
      .enable      (enable[i]),
      .cfg_we      (chan_we_s[i]),
      .cfg_div     (cfg_div),
      .newclk      (newclk[i]),
      .tick        (tick[i]),
      .cfg_pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: a 4-channel and a 3-channel instance, both with
// DEFAULT_DIV=5, checked against a timestamp-based reference model
// (each channel remembers the absolute edge of its next toggle).
module tb_clkdiv_multi;

  logic        inclk = 1'b0;
  always #5 inclk = ~inclk;

  logic        reset, sync, cfg_we_a, cfg_we_b;
  logic [3:0]  enable_a;
  logic [2:0]  enable_b;
  logic [1:0]  cfg_chan_a, cfg_chan_b;
  logic [31:0] cfg_div;
  logic [3:0]  newclk_a, tick_a, pend_a;
  logic [2:0]  newclk_b, tick_b, pend_b;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  localparam longint DEFD = 5;

  typedef struct {
    bit     lvl;
    bit     tk;
    bit     pf;
    longint nxt;
    longint act;
    longint pend;
  } mch_t;

  mch_t ma [4];
  mch_t mb [3];

  clkdiv_multi #(.NCHAN(4), .WIDTH(32), .DEFAULT_DIV(32'd5)) dut_a (
    .inclk(inclk), .reset(reset), .enable(enable_a), .sync(sync),
    .cfg_we(cfg_we_a), .cfg_chan(cfg_chan_a), .cfg_div(cfg_div),
    .newclk(newclk_a), .tick(tick_a), .cfg_pending(pend_a));

  clkdiv_multi #(.NCHAN(3), .WIDTH(32), .DEFAULT_DIV(32'd5)) dut_b (
    .inclk(inclk), .reset(reset), .enable(enable_b), .sync(sync),
    .cfg_we(cfg_we_b), .cfg_chan(cfg_chan_b), .cfg_div(cfg_div),
    .newclk(newclk_b), .tick(tick_b), .cfg_pending(pend_b));

  // Reference: a restart or boundary at edge n schedules the next toggle at n+1+div.
  function automatic mch_t mstep(mch_t c, bit rst, bit syn, bit en, bit we,
                                 longint d, longint n);
    mch_t r = c;
    if (rst) begin
      r.lvl = 1'b0; r.tk = 1'b0; r.pf = 1'b0;
      r.act = DEFD; r.pend = DEFD; r.nxt = n + 1 + DEFD;
    end else if (syn) begin
      r.lvl = 1'b0; r.tk = 1'b0; r.pf = 1'b0;
      if (we) r.pend = d;
      r.act = r.pend; r.nxt = n + 1 + r.act;
    end else if (!en) begin
      r.lvl = 1'b0; r.tk = 1'b0;
      r.act = c.pend; r.pf = we;
      if (we) r.pend = d;
      r.nxt = n + 1 + r.act;
    end else if (n == c.nxt) begin
      r.tk = !c.lvl; r.lvl = !c.lvl; r.pf = 1'b0;
      if (we) r.pend = d;
      r.act = r.pend; r.nxt = n + 1 + r.act;
    end else begin
      r.tk = 1'b0;
      if (we) begin r.pend = d; r.pf = 1'b1; end
    end
    return r;
  endfunction

  function automatic logic [20:0] exp_v();
    logic [3:0] n4, t4, p4;
    logic [2:0] n3, t3, p3;
    for (int i = 0; i < 4; i++) begin n4[i] = ma[i].lvl; t4[i] = ma[i].tk; p4[i] = ma[i].pf; end
    for (int i = 0; i < 3; i++) begin n3[i] = mb[i].lvl; t3[i] = mb[i].tk; p3[i] = mb[i].pf; end
    return {n4, t4, p4, n3, t3, p3};
  endfunction

  function automatic logic [20:0] got_v();
    return {newclk_a, tick_a, pend_a, newclk_b, tick_b, pend_b};
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge.
  task automatic cycle();
    @(posedge inclk);
    for (int i = 0; i < 4; i++)
      ma[i] = mstep(ma[i], reset, sync, enable_a[i], cfg_we_a && (int'(cfg_chan_a) == i),
                    longint'(cfg_div), cyc);
    for (int i = 0; i < 3; i++)
      mb[i] = mstep(mb[i], reset, sync, enable_b[i], cfg_we_b && (int'(cfg_chan_b) == i),
                    longint'(cfg_div), cyc);
    cyc++;
    @(negedge inclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (got_v() !== 21'd0) begin
        errors++; $display("FAIL reset_zero cyc=%0d got=%h exp=%h", cyc, got_v(), 21'd0);
      end
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_legacy();
    longint last_rise, last_fall, last_tick;
    logic   prev;
    last_rise = -1; last_fall = -1; last_tick = -1; prev = 1'b0;
    enable_a = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      cycle();
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL legacy_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
      checks++;
      if (tick_a[0] !== (newclk_a[0] & ~prev)) begin
        errors++; $display("FAIL legacy_tick_edge cyc=%0d got=%b exp=%b", cyc, tick_a[0], newclk_a[0] & ~prev);
      end
      checks++;
      if ({newclk_a[3:1], tick_a[3:1]} !== 6'd0) begin
        errors++; $display("FAIL legacy_others cyc=%0d got=%h exp=0", cyc, {newclk_a[3:1], tick_a[3:1]});
      end
      if (newclk_a[0] && !prev) begin
        if (last_fall >= 0) begin
          checks++;
          if (cyc - last_fall != 6) begin
            errors++; $display("FAIL legacy_low_len got=%0d exp=6", cyc - last_fall);
          end
        end
        last_rise = cyc;
      end
      if (!newclk_a[0] && prev) begin
        checks++;
        if (cyc - last_rise != 6) begin
          errors++; $display("FAIL legacy_high_len got=%0d exp=6", cyc - last_rise);
        end
        last_fall = cyc;
      end
      if (tick_a[0]) begin
        if (last_tick >= 0) begin
          checks++;
          if (cyc - last_tick != 12) begin
            errors++; $display("FAIL legacy_tick_period got=%0d exp=12", cyc - last_tick);
          end
        end
        last_tick = cyc;
      end
      prev = newclk_a[0];
    end
  endtask

  task automatic test_min_div();
    logic prev;
    cfg_we_a = 1'b1; cfg_chan_a = 2'd1; cfg_div = 32'd0;
    cycle();
    cfg_we_a = 1'b0;
    checks++;
    if (pend_a[1] !== 1'b1) begin
      errors++; $display("FAIL min_pend_set got=%b exp=1", pend_a[1]);
    end
    cycle();
    checks++;
    if (pend_a[1] !== 1'b0) begin
      errors++; $display("FAIL min_pend_clear got=%b exp=0", pend_a[1]);
    end
    enable_a = 4'b0011;
    prev = newclk_a[1];
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL min_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
      checks++;
      if ({newclk_a[1], tick_a[1]} !== {~prev, ~prev}) begin
        errors++; $display("FAIL min_toggle cyc=%0d got=%b exp=%b", cyc, {newclk_a[1], tick_a[1]}, {~prev, ~prev});
      end
      prev = newclk_a[1];
    end
  endtask

  task automatic test_glitch();
    logic exp_clk, exp_pend;
    enable_a = 4'b0000;
    cfg_we_a = 1'b1; cfg_chan_a = 2'd0; cfg_div = 32'd9;
    cycle();
    cfg_we_a = 1'b0;
    cycle();
    enable_a = 4'b0001;
    for (int off = 0; off < 4; off++) cycle();
    cfg_we_a = 1'b1; cfg_chan_a = 2'd0; cfg_div = 32'd2;
    cycle();
    cfg_we_a = 1'b0;
    for (int off = 5; off <= 15; off++) begin
      cycle();
      exp_clk  = (off >= 9 && off <= 11) || (off >= 15);
      exp_pend = (off < 9);
      checks++;
      if ({newclk_a[0], pend_a[0]} !== {exp_clk, exp_pend}) begin
        errors++; $display("FAIL glitch_half off=%0d got=%b exp=%b", off, {newclk_a[0], pend_a[0]}, {exp_clk, exp_pend});
      end
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_sync();
    int   d [4];
    int   p;
    logic exp_clk, exp_tk;
    d = '{3, 4, 5, 6};
    enable_a = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cfg_we_a = 1'b1; cfg_chan_a = 2'(i); cfg_div = 32'(d[i]);
      cycle();
    end
    cfg_we_a = 1'b0;
    cycle();
    enable_a = 4'b1111;
    repeat (7) cycle();
    d[2] = 1;
    sync = 1'b1; cfg_we_a = 1'b1; cfg_chan_a = 2'd2; cfg_div = 32'd1;
    cycle();
    sync = 1'b0; cfg_we_a = 1'b0;
    checks++;
    if ({newclk_a, pend_a[2]} !== 5'd0) begin
      errors++; $display("FAIL sync_clear got=%b exp=00000", {newclk_a, pend_a[2]});
    end
    for (int j = 1; j <= 14; j++) begin
      cycle();
      for (int i = 0; i < 4; i++) begin
        p = j - (d[i] + 1);
        exp_clk = (p >= 0) && ((p / (d[i] + 1)) % 2 == 0);
        exp_tk  = (p >= 0) && (p % (2 * (d[i] + 1)) == 0);
        checks++;
        if ({newclk_a[i], tick_a[i]} !== {exp_clk, exp_tk}) begin
          errors++; $display("FAIL sync_phase ch=%0d j=%0d got=%b exp=%b", i, j, {newclk_a[i], tick_a[i]}, {exp_clk, exp_tk});
        end
      end
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL sync_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_invalid();
    logic exp_clk, exp_pend;
    enable_b = 3'b000;
    cycle();
    enable_b = 3'b001;
    cycle();
    cfg_we_b = 1'b1; cfg_chan_b = 2'd3; cfg_div = 32'd1;
    cycle();
    cfg_we_b = 1'b0;
    checks++;
    if (pend_b !== 3'b000) begin
      errors++; $display("FAIL invalid_chan got=%b exp=000", pend_b);
    end
    cfg_we_b = 1'b1; cfg_chan_b = 2'd0; cfg_div = 32'd7;
    cycle();
    cfg_div = 32'd1;
    cycle();
    cfg_we_b = 1'b0;
    checks++;
    if (pend_b !== 3'b001) begin
      errors++; $display("FAIL overwrite_pend got=%b exp=001", pend_b);
    end
    for (int off = 4; off <= 12; off++) begin
      cycle();
      exp_clk  = (off >= 5 && off <= 6) || (off >= 9 && off <= 10);
      exp_pend = (off < 5);
      checks++;
      if ({newclk_b[0], pend_b[0]} !== {exp_clk, exp_pend}) begin
        errors++; $display("FAIL overwrite_apply off=%0d got=%b exp=%b", off, {newclk_b[0], pend_b[0]}, {exp_clk, exp_pend});
      end
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL invalid_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
    end
    enable_b = 3'b000;
  endtask

  task automatic test_reset_mid();
    bit   found;
    logic exp_clk;
    found = 1'b0;
    enable_a = 4'b0001;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (newclk_a[0]) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL reset_mid_timeout got=%b exp=1", newclk_a[0]);
    end
    cfg_we_a = 1'b1; cfg_chan_a = 2'd0; cfg_div = 32'd7;
    cycle();
    cfg_we_a = 1'b0;
    checks++;
    if ({newclk_a[0], pend_a[0]} !== 2'b11) begin
      errors++; $display("FAIL reset_mid_pre got=%b exp=11", {newclk_a[0], pend_a[0]});
    end
    reset = 1'b1; cfg_we_a = 1'b1; cfg_chan_a = 2'd0; cfg_div = 32'd9;
    cycle();
    reset = 1'b0; cfg_we_a = 1'b0;
    checks++;
    if ({newclk_a, tick_a, pend_a} !== 12'd0) begin
      errors++; $display("FAIL reset_mid_clear got=%h exp=000", {newclk_a, tick_a, pend_a});
    end
    for (int j = 1; j <= 12; j++) begin
      cycle();
      exp_clk = (j >= 6 && j <= 11);
      checks++;
      if (newclk_a[0] !== exp_clk) begin
        errors++; $display("FAIL reset_mid_default j=%0d got=%b exp=%b", j, newclk_a[0], exp_clk);
      end
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL reset_mid_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 9) == 0) enable_a = 4'($urandom);
      if ($urandom_range(0, 9) == 0) enable_b = 3'($urandom);
      cfg_we_a   = ($urandom_range(0, 5) == 0);
      cfg_we_b   = ($urandom_range(0, 5) == 0);
      cfg_chan_a = 2'($urandom);
      cfg_chan_b = 2'($urandom);
      cfg_div    = ($urandom_range(0, 40) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 6));
      sync       = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, got_v(), exp_v());
      end
    end
    reset = 1'b0; sync = 1'b0; cfg_we_a = 1'b0; cfg_we_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sync = 1'b0; cfg_we_a = 1'b0; cfg_we_b = 1'b0;
    enable_a = 4'b0000; enable_b = 3'b000;
    cfg_chan_a = 2'd0; cfg_chan_b = 2'd0; cfg_div = 32'd0;
    test_reset();
    test_legacy();
    test_min_div();
    test_glitch();
    test_sync();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
